// File: rtl/mlp_controller_pkg.sv
// Shared constants and state encoding for the 62-30-10 MLP sequencer.
// Latency 107 cycles per sample; no backpressure, the datapath follows every strobe.
package mlp_controller_pkg;

  localparam int N_HID    = 30;
  localparam int N_OUT    = 10;
  localparam int N_PU     = 8;
  localparam int H_CHUNKS = 8;
  localparam int O_BASE   = 4;
  localparam int O_CHUNKS = 4;
  localparam int H_GROUPS = (N_HID + N_PU - 1) / N_PU;
  localparam int O_GROUPS = (N_OUT + N_PU - 1) / N_PU;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LDX  = 4'd1,
    S_LDW  = 4'd2,
    S_CLR  = 4'd3,
    S_MAC  = 4'd4,
    S_TAIL = 4'd5,
    S_BIAS = 4'd6,
    S_WR   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  function automatic logic [4:0] last_chunk(input logic out_layer);
    return out_layer ? 5'(O_CHUNKS - 1) : 5'(H_CHUNKS - 1);
  endfunction

endpackage

// File: rtl/mlp_controller_onehot_dec.sv
// Index + enable to W-bit one-hot decoder; purely combinational, zero latency.
module onehot_dec #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [W-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < W; i++) begin
      onehot[i] = en && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/mlp_controller.sv
// Per-sample sequencer: LDX, LDW, groups of {CLR, MAC, TAIL, BIAS, WR} per layer, then DONE.
// 107 cycles per sample; free-running, start is only honoured in IDLE.
module mlp_controller
  import mlp_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  num_samples,
  input  logic [4:0]  cnt_out,
  output logic        busy,
  output logic        sample_done,
  output logic        all_done,
  output logic        rst_cnt,
  output logic        cnt,
  output logic        mem_read,
  output logic        ld_x,
  output logic        sel_h_o,
  output logic        ld_mult,
  output logic        acc,
  output logic        ld_add,
  output logic [4:0]  addr1,
  output logic [3:0]  addr2,
  output logic [9:0]  addr3,
  output logic [2:0]  sel_64bit,
  output logic [2:0]  sel_reg,
  output logic [29:0] ld,
  output logic [29:0] ld_out_h,
  output logic [9:0]  ld_out_o
);

  state_t      state, state_nx;
  logic        layer;
  logic [4:0]  nrn;
  logic [1:0]  grp;
  logic [9:0]  last_addr;
  logic        nrn_last, grp_last, smp_last;
  logic        ld_en, wr_en;
  logic [H_GROUPS-1:0] grp_h;
  logic [O_GROUPS-1:0] grp_o;

  assign nrn_last = layer ? (nrn == 5'(N_OUT - 1)) : (nrn == 5'(N_HID - 1));
  assign grp_last = layer ? (grp == 2'(O_GROUPS - 1)) : (grp == 2'(H_GROUPS - 1));
  assign smp_last = (addr3 == last_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Sequencing counters; num_samples-1 wraps 0 to 1023 so a count of 0 runs 1024 samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer     <= 1'b0;
      nrn       <= '0;
      grp       <= '0;
      addr3     <= '0;
      last_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          layer     <= 1'b0;
          nrn       <= '0;
          grp       <= '0;
          addr3     <= '0;
          last_addr <= num_samples - 10'd1;
        end
        S_LDW: nrn <= nrn_last ? '0 : nrn + 5'd1;
        S_WR: begin
          if (grp_last) begin
            grp   <= '0;
            layer <= 1'b1;
          end else begin
            grp <= grp + 2'd1;
          end
        end
        S_DONE: if (!smp_last) begin
          addr3 <= addr3 + 10'd1;
          layer <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    sample_done = 1'b0;
    all_done    = 1'b0;
    rst_cnt     = 1'b0;
    cnt         = 1'b0;
    mem_read    = 1'b0;
    ld_x        = 1'b0;
    ld_mult     = 1'b0;
    acc         = 1'b0;
    ld_add      = 1'b0;
    sel_64bit   = 3'd0;
    ld_en       = 1'b0;
    wr_en       = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_LDX;
      S_LDX: begin
        mem_read = 1'b1;
        ld_x     = 1'b1;
        state_nx = S_LDW;
      end
      S_LDW: begin
        mem_read = 1'b1;
        ld_en    = 1'b1;
        if (nrn_last) state_nx = S_CLR;
      end
      S_CLR: begin
        rst_cnt  = 1'b1;
        state_nx = S_MAC;
      end
      S_MAC: begin
        cnt       = 1'b1;
        ld_mult   = 1'b1;
        // The counter is cleared in CLR, so a zero count marks the first product.
        acc       = (cnt_out != 5'd0);
        sel_64bit = (layer ? 3'(O_BASE) : 3'd0) + cnt_out[2:0];
        if (cnt_out == last_chunk(layer)) state_nx = S_TAIL;
      end
      S_TAIL: begin
        acc      = 1'b1;
        state_nx = S_BIAS;
      end
      S_BIAS: begin
        ld_add   = 1'b1;
        state_nx = S_WR;
      end
      S_WR: begin
        wr_en = 1'b1;
        if (!grp_last) state_nx = S_CLR;
        else           state_nx = layer ? S_DONE : S_LDX;
      end
      S_DONE: begin
        sample_done = 1'b1;
        if (smp_last) begin
          all_done = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_LDX;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign sel_h_o = busy && layer;
  assign sel_reg = (state inside {S_CLR, S_MAC, S_TAIL, S_BIAS, S_WR}) ? {1'b0, grp} : 3'd0;
  assign addr1   = (ld_en && !layer) ? nrn : 5'd0;
  assign addr2   = (ld_en && layer) ? nrn[3:0] : 4'd0;

  onehot_dec #(.W(N_HID)) u_ld_dec (
    .idx    (nrn),
    .en     (ld_en),
    .onehot (ld)
  );

  onehot_dec #(.W(H_GROUPS)) u_wr_h_dec (
    .idx    (grp),
    .en     (wr_en && !layer),
    .onehot (grp_h)
  );

  onehot_dec #(.W(O_GROUPS)) u_wr_o_dec (
    .idx    (grp[0]),
    .en     (wr_en && layer),
    .onehot (grp_o)
  );

  // Each group enable fans out to its N_PU result registers; bits past the layer width drop off.
  always_comb begin
    ld_out_h = '0;
    ld_out_o = '0;
    for (int j = 0; j < N_HID; j++) ld_out_h[j] = grp_h[j / N_PU];
    for (int j = 0; j < N_OUT; j++) ld_out_o[j] = grp_o[j / N_PU];
  end

endmodule

// File: tb/tb_mlp_controller.sv
// Directed bench for mlp_controller with a behavioural chunk counter standing in for the datapath.
module tb_mlp_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  num_samples;
  logic [4:0]  cnt_out;
  logic        busy, sample_done, all_done, rst_cnt, cnt, mem_read, ld_x, sel_h_o;
  logic        ld_mult, acc, ld_add;
  logic [4:0]  addr1;
  logic [3:0]  addr2;
  logic [9:0]  addr3;
  logic [2:0]  sel_64bit, sel_reg;
  logic [29:0] ld, ld_out_h;
  logic [9:0]  ld_out_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mlp_controller dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .cnt_out(cnt_out),
    .busy(busy), .sample_done(sample_done), .all_done(all_done), .rst_cnt(rst_cnt),
    .cnt(cnt), .mem_read(mem_read), .ld_x(ld_x), .sel_h_o(sel_h_o), .ld_mult(ld_mult),
    .acc(acc), .ld_add(ld_add), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .sel_64bit(sel_64bit), .sel_reg(sel_reg), .ld(ld), .ld_out_h(ld_out_h), .ld_out_o(ld_out_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt_out <= '0;
    else if (rst_cnt) cnt_out <= '0;
    else if (cnt)     cnt_out <= cnt_out + 5'd1;
  end

  function automatic logic any_out();
    return |{busy, sample_done, all_done, rst_cnt, cnt, mem_read, ld_x, sel_h_o, ld_mult, acc,
             ld_add, addr1, addr2, addr3, sel_64bit, sel_reg, ld, ld_out_h, ld_out_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int          n_ld;
  int          done_cyc[$];
  logic [9:0]  done_addr[$];
  int          all_cyc[$];
  logic        busy_after;
  int          seen;

  initial begin
    rst = 1'b0;
    start = 1'b1;
    num_samples = 10'd1;
    repeat (3) tick();
    chk("reset_outputs_zero", any_out(), 0);
    chk("reset_busy", busy, 0);
    rst = 1'b1;
    start = 1'b0;
    tick();
    chk("idle_after_release", any_out(), 0);

    // Single sample: cycle 1 is the first LDX, DONE lands on cycle 107.
    start = 1'b1;
    for (int c = 1; c <= 108; c++) begin
      tick();
      start = 1'b0;
      if (c <= 107) begin
        chk("sample_done_timing", sample_done, (c == 107));
        chk("all_done_timing", all_done, (c == 107));
        chk("busy_in_run", busy, 1);
        n_ld = int'(ld != 0) + int'(ld_out_h != 0) + int'(ld_out_o != 0);
        chk("ld_exclusive", (n_ld <= 1), 1);
      end
      if (c == 1)  chk("ldx_h", {ld_x, mem_read, sel_h_o}, 3'b110);
      if (c >= 2 && c <= 31) begin
        chk("ldw_h_ld", ld, 30'(1) << (c - 2));
        chk("ldw_h_addr1", addr1, c - 2);
        chk("ldw_h_rd_sel", {mem_read, sel_h_o}, 2'b10);
      end
      if (c >= 33 && c <= 40) chk("mac_h_sel64", sel_64bit, c - 33);
      if (c == 43) chk("wr_h_g0", ld_out_h, 30'h000000FF);
      if (c == 55) chk("wr_h_g1", ld_out_h, 30'h0000FF00);
      if (c == 67) begin
        chk("wr_h_g2", ld_out_h, 30'h00FF0000);
        chk("wr_h_g2_selreg", sel_reg, 2);
      end
      if (c == 79) chk("wr_h_g3", ld_out_h, 30'h3F000000);
      if (c == 80) chk("ldx_o", {ld_x, mem_read, sel_h_o}, 3'b111);
      if (c >= 81 && c <= 90) begin
        chk("ldw_o_ld", ld, 30'(1) << (c - 81));
        chk("ldw_o_addr2", addr2, c - 81);
      end
      if (c >= 92 && c <= 95) begin
        chk("mac_o_sel64", sel_64bit, 4 + (c - 92));
        chk("mac_o_acc", acc, (c != 92));
        chk("mac_o_ldmult", ld_mult, 1);
      end
      if (c == 96)  chk("tail_o_acc", acc, 1);
      if (c == 97)  chk("bias_o_ldadd", ld_add, 1);
      if (c == 98)  chk("wr_o_g0", ld_out_o, 10'h0FF);
      if (c == 99)  chk("clr_o_g1", {rst_cnt, sel_reg}, 4'b1001);
      if (c == 106) chk("wr_o_g1", ld_out_o, 10'h300);
      if (c == 108) chk("busy_drop", busy, 0);
    end

    // Three samples with a stray start pulse mid-run.
    num_samples = 10'd3;
    start = 1'b1;
    busy_after = 1'b1;
    for (int k = 1; k <= 330; k++) begin
      tick();
      start = (k == 49);
      if (sample_done) begin
        done_cyc.push_back(k);
        done_addr.push_back(addr3);
      end
      if (all_done) all_cyc.push_back(k);
      if (k == 322) busy_after = busy;
    end
    chk("multi_done_count", done_cyc.size(), 3);
    chk("multi_all_count", all_cyc.size(), 1);
    if (done_cyc.size() == 3) begin
      chk("multi_done0_cyc", done_cyc[0], 107);
      chk("multi_done1_cyc", done_cyc[1], 214);
      chk("multi_done2_cyc", done_cyc[2], 321);
      chk("multi_addr0", done_addr[0], 0);
      chk("multi_addr1", done_addr[1], 1);
      chk("multi_addr2", done_addr[2], 2);
    end
    if (all_cyc.size() == 1) chk("multi_all_cyc", all_cyc[0], 321);
    chk("multi_busy_after", busy_after, 0);
    chk("multi_addr3_hold", addr3, 2);

    // Asynchronous abort during hidden MAC.
    num_samples = 10'd1;
    start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      start = 1'b0;
    end
    chk("abort_pre_mac", {cnt, ld_mult}, 2'b11);
    rst = 1'b0;
    #1;
    chk("abort_outputs_zero", any_out(), 0);
    tick();
    chk("abort_still_zero", any_out(), 0);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (sample_done || all_done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
